// File: rtl/multichannel_lockin_if.sv
// -----------------------------------------------------------------------------
// multichannel_lockin_if
// Bundles the sample-side inputs and the result-side outputs of the
// time-multiplexed lock-in demodulator. Clock and reset stay plain ports on
// the module.
//
// Handshake: tick_i is a one-cycle strobe with no back-pressure. A tick is
// consumed only when the core is idle (busy_o == 0) and clear_i is low.
// Otherwise it is dropped. A tick dropped because the core was busy sets the
// sticky missed_o flag. done_o is a one-cycle strobe marking new x_o/y_o.
//
// Signals (master = producer of samples, slave = lock-in core):
//   clear_i  : synchronous clear of integration state
//   tick_i   : new-sample strobe
//   data_i   : NUM_CH packed signed samples, channel k at [k*DATA_W +: DATA_W]
//   sin_i    : signed in-phase reference
//   cos_i    : signed quadrature reference
//   x_o/y_o  : NUM_CH packed signed results, channel k at [k*OUT_W +: OUT_W]
//   done_o   : one-cycle strobe coincident with new x_o/y_o
//   busy_o   : core not idle
//   count_o  : number of done_o pulses, wraps
//   missed_o : sticky, a tick arrived while busy
//   state_o  : debug view of the FSM state (0 IDLE, 1 MAC, 2 DUMP)
// -----------------------------------------------------------------------------
interface multichannel_lockin_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 24,
    parameter int OUT_W  = 32
);
    logic                       clear_i;
    logic                       tick_i;
    logic [NUM_CH*DATA_W-1:0]   data_i;
    logic [DATA_W-1:0]          sin_i;
    logic [DATA_W-1:0]          cos_i;
    logic [NUM_CH*OUT_W-1:0]    x_o;
    logic [NUM_CH*OUT_W-1:0]    y_o;
    logic                       done_o;
    logic                       busy_o;
    logic [31:0]                count_o;
    logic                       missed_o;
    logic [1:0]                 state_o;

    modport master (
        output clear_i, tick_i, data_i, sin_i, cos_i,
        input  x_o, y_o, done_o, busy_o, count_o, missed_o, state_o
    );

    modport slave (
        input  clear_i, tick_i, data_i, sin_i, cos_i,
        output x_o, y_o, done_o, busy_o, count_o, missed_o, state_o
    );
endinterface

// File: rtl/multichannel_lockin.sv
// -----------------------------------------------------------------------------
// multichannel_lockin
// Time-multiplexed lock-in demodulator. A single multiplier pair walks over
// NUM_CH channels per reference sample, accumulating d*sin and d*cos. After
// DECIM samples the accumulators are dumped (top OUT_W bits, floor) into the
// output registers and cleared.
//
// Ports:
//   clk_i    : system clock
//   reset_ni : asynchronous active-low reset
//   bus      : multichannel_lockin_if.slave (samples in, results out)
//
// Timing for a tick in cycle 0: snapshot at the end of cycle 0, MAC in cycles
// 1..NUM_CH, DUMP in cycle NUM_CH+1 (final sample only), done_o and new
// results in cycle NUM_CH+2.
// -----------------------------------------------------------------------------
module multichannel_lockin #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 24,
    parameter int DECIM  = 16,
    parameter int OUT_W  = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    multichannel_lockin_if.slave   bus
);
    localparam int ACC_W  = 2*DATA_W + $clog2(DECIM);
    localparam int PROD_W = 2*DATA_W;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DUMP = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic signed [DATA_W-1:0]    snap_q [NUM_CH];
    logic signed [DATA_W-1:0]    sin_q, cos_q;
    logic signed [ACC_W-1:0]     acc_x_q [NUM_CH];
    logic signed [ACC_W-1:0]     acc_y_q [NUM_CH];
    logic [OUT_W-1:0]            x_q [NUM_CH];
    logic [OUT_W-1:0]            y_q [NUM_CH];
    logic                        done_q;
    logic                        busy_q;
    logic [31:0]                 count_q;
    logic                        missed_q;

    // Control decodes
    logic                        last_ch;
    logic                        last_sample;
    logic                        accept;
    logic                        mac_en;
    logic                        dump_en;
    logic                        miss_set;

    // Datapath
    logic signed [DATA_W-1:0]    d_sel;
    logic signed [PROD_W-1:0]    prod_x, prod_y;
    logic [NUM_CH*OUT_W-1:0]     x_pack, y_pack;

    assign last_ch     = (ch_q == CH_W'(NUM_CH-1));
    assign last_sample = (cnt_q == CNT_W'(DECIM-1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        if (bus.clear_i) begin
            // Clear aborts any integration in flight, including a pending dump.
            state_d = IDLE;
            ch_d    = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.tick_i) state_d = MAC;
                end
                MAC: begin
                    if (last_ch) begin
                        ch_d = '0;
                        if (last_sample) begin
                            state_d = DUMP;
                            cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
                DUMP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        accept   = 1'b0;
        mac_en   = 1'b0;
        dump_en  = 1'b0;
        miss_set = 1'b0;
        if (!bus.clear_i) begin
            accept   = (state_q == IDLE) && bus.tick_i;
            mac_en   = (state_q == MAC);
            dump_en  = (state_q == DUMP);
            // A tick dropped by clear is not a miss; only one dropped for busy is.
            miss_set = (state_q != IDLE) && bus.tick_i;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        d_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) d_sel = snap_q[k];
        end
    end

    // Sign-extend both operands to the product width; the low PROD_W bits of
    // the unsigned product are the exact two's-complement signed product.
    assign prod_x = $signed({{DATA_W{d_sel[DATA_W-1]}}, d_sel} *
                            {{DATA_W{sin_q[DATA_W-1]}}, sin_q});
    assign prod_y = $signed({{DATA_W{d_sel[DATA_W-1]}}, d_sel} *
                            {{DATA_W{cos_q[DATA_W-1]}}, cos_q});

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < NUM_CH; k++) snap_q[k] <= '0;
            sin_q <= '0;
            cos_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_CH; k++) snap_q[k] <= bus.data_i[k*DATA_W +: DATA_W];
            sin_q <= bus.sin_i;
            cos_q <= bus.cos_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_x_q[k] <= '0;
                acc_y_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.clear_i || dump_en) begin
                    acc_x_q[k] <= '0;
                    acc_y_q[k] <= '0;
                end else if (mac_en && (ch_q == CH_W'(k))) begin
                    acc_x_q[k] <= acc_x_q[k] + ACC_W'(prod_x);
                    acc_y_q[k] <= acc_y_q[k] + ACC_W'(prod_y);
                end
            end
        end
    end

    // Dump takes the top OUT_W accumulator bits: an arithmetic shift, i.e. floor.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < NUM_CH; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= dump_en;
            if (dump_en) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    x_q[k] <= acc_x_q[k][ACC_W-1 -: OUT_W];
                    y_q[k] <= acc_y_q[k][ACC_W-1 -: OUT_W];
                end
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            if (bus.clear_i)   missed_q <= 1'b0;
            else if (miss_set) missed_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        x_pack = '0;
        y_pack = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            x_pack[k*OUT_W +: OUT_W] = x_q[k];
            y_pack[k*OUT_W +: OUT_W] = y_q[k];
        end
    end

    assign bus.x_o      = x_pack;
    assign bus.y_o      = y_pack;
    assign bus.done_o   = done_q;
    assign bus.busy_o   = busy_q;
    assign bus.count_o  = count_q;
    assign bus.missed_o = missed_q;
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_multichannel_lockin.sv
module tb_multichannel_lockin;
    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    // Configuration A: two channels, DECIM=4 (output = acc[49:18])
    multichannel_lockin_if #(.NUM_CH(2), .DATA_W(24), .OUT_W(32)) bus_a ();
    // Configuration B: one channel, DECIM=1 (output = acc[47:16])
    multichannel_lockin_if #(.NUM_CH(1), .DATA_W(24), .OUT_W(32)) bus_b ();

    multichannel_lockin #(.NUM_CH(2), .DATA_W(24), .DECIM(4), .OUT_W(32)) dut_a (
        .clk_i(clk), .reset_ni(reset_n), .bus(bus_a.slave)
    );
    multichannel_lockin #(.NUM_CH(1), .DATA_W(24), .DECIM(1), .OUT_W(32)) dut_b (
        .clk_i(clk), .reset_ni(reset_n), .bus(bus_b.slave)
    );

    // ------------------------------------------------------------ clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ drivers
    task automatic set_a(input logic [23:0] d0, input logic [23:0] d1,
                         input logic [23:0] s, input logic [23:0] c);
        bus_a.data_i = {d1, d0};
        bus_a.sin_i  = s;
        bus_a.cos_i  = c;
    endtask

    // Tick held for 'hold' cycles starting in cycle 0, then watch done_o in
    // cycles hold..n. Returns first done cycle (-1 if none) and pulse count.
    // Leaves the caller at the start of cycle n+1.
    task automatic tick_a(input int hold, input int n, output int first_done, output int n_done);
        first_done = -1;
        n_done     = 0;
        bus_a.tick_i = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus_a.tick_i = 1'b0;
        for (int c = hold; c <= n; c++) begin
            @(negedge clk);
            if (bus_a.done_o === 1'b1) begin
                if (first_done < 0) first_done = c;
                n_done++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_b(input int n, output int first_done, output int n_done);
        first_done = -1;
        n_done     = 0;
        bus_b.tick_i = 1'b1;
        @(posedge clk);
        #1 bus_b.tick_i = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (bus_b.done_o === 1'b1) begin
                if (first_done < 0) first_done = c;
                n_done++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_a();
        bus_a.clear_i = 1'b1;
        @(posedge clk);
        #1 bus_a.clear_i = 1'b0;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        @(negedge clk);
        tests_run++; if (bus_a.x_o !== 64'd0) begin tests_failed++; $display("FAIL reset_x got %0h exp 0", bus_a.x_o); end
        tests_run++; if (bus_a.y_o !== 64'd0) begin tests_failed++; $display("FAIL reset_y got %0h exp 0", bus_a.y_o); end
        tests_run++; if (bus_a.count_o !== 32'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", bus_a.count_o); end
        tests_run++; if ({bus_a.done_o, bus_a.busy_o, bus_a.missed_o} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b exp 000", {bus_a.done_o, bus_a.busy_o, bus_a.missed_o}); end
        tests_run++; if (bus_a.state_o !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d exp 0", bus_a.state_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int fd, nd;
        set_a(24'd1000, -24'sd1000, 24'd4194304, 24'd0);
        for (int i = 0; i < 4; i++) begin
            tick_a(1, 9, fd, nd);
            if (i < 3) begin
                tests_run++; if (nd !== 0) begin tests_failed++; $display("FAIL basic_early_done tick %0d got %0d pulses exp 0", i, nd); end
            end else begin
                tests_run++; if (fd !== 4) begin tests_failed++; $display("FAIL basic_done_cycle got %0d exp 4", fd); end
                tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL basic_done_pulses got %0d exp 1", nd); end
            end
        end
        @(negedge clk);
        tests_run++; if (bus_a.x_o[31:0] !== 32'd64000) begin tests_failed++; $display("FAIL basic_x0 got %0d exp 64000", $signed(bus_a.x_o[31:0])); end
        tests_run++; if (bus_a.x_o[63:32] !== -32'sd64000) begin tests_failed++; $display("FAIL basic_x1 got %0d exp -64000", $signed(bus_a.x_o[63:32])); end
        tests_run++; if (bus_a.y_o !== 64'd0) begin tests_failed++; $display("FAIL basic_y got %0h exp 0", bus_a.y_o); end
        tests_run++; if (bus_a.count_o !== 32'd1) begin tests_failed++; $display("FAIL basic_count got %0d exp 1", bus_a.count_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_extreme();
        int fd, nd;
        set_a(-24'sd8388608, -24'sd8388608, -24'sd8388608, -24'sd8388608);
        for (int i = 0; i < 4; i++) tick_a(1, 9, fd, nd);
        tests_run++; if (fd !== 4) begin tests_failed++; $display("FAIL extreme_done_cycle got %0d exp 4", fd); end
        @(negedge clk);
        tests_run++; if (bus_a.x_o !== {32'h4000_0000, 32'h4000_0000}) begin tests_failed++; $display("FAIL extreme_x got %0h exp 4000000040000000", bus_a.x_o); end
        tests_run++; if (bus_a.y_o !== {32'h4000_0000, 32'h4000_0000}) begin tests_failed++; $display("FAIL extreme_y got %0h exp 4000000040000000", bus_a.y_o); end
        tests_run++; if (bus_a.count_o !== 32'd2) begin tests_failed++; $display("FAIL extreme_count got %0d exp 2", bus_a.count_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_missed();
        int fd, nd;
        set_a(24'd1000, -24'sd1000, 24'd4194304, 24'd0);
        tick_a(2, 9, fd, nd);
        tests_run++; if (bus_a.missed_o !== 1'b1) begin tests_failed++; $display("FAIL missed_set got %b exp 1", bus_a.missed_o); end
        for (int i = 0; i < 3; i++) tick_a(1, 9, fd, nd);
        tests_run++; if (fd !== 4) begin tests_failed++; $display("FAIL missed_done_cycle got %0d exp 4", fd); end
        @(negedge clk);
        tests_run++; if (bus_a.x_o[31:0] !== 32'd64000) begin tests_failed++; $display("FAIL missed_x0 got %0d exp 64000", $signed(bus_a.x_o[31:0])); end
        tests_run++; if (bus_a.missed_o !== 1'b1) begin tests_failed++; $display("FAIL missed_sticky got %b exp 1", bus_a.missed_o); end
        @(posedge clk); #1;
        clear_a();
        @(negedge clk);
        tests_run++; if (bus_a.missed_o !== 1'b0) begin tests_failed++; $display("FAIL missed_clear got %b exp 0", bus_a.missed_o); end
        tests_run++; if (bus_a.count_o !== 32'd3) begin tests_failed++; $display("FAIL missed_count got %0d exp 3", bus_a.count_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        int fd, nd;
        int total;
        total = 0;
        set_a(24'd5000, 24'd7000, 24'd4194304, 24'd4194304);
        for (int i = 0; i < 2; i++) begin tick_a(1, 9, fd, nd); total += nd; end
        clear_a();
        @(negedge clk);
        tests_run++; if (total !== 0) begin tests_failed++; $display("FAIL clear_no_done got %0d pulses exp 0", total); end
        tests_run++; if (bus_a.x_o[31:0] !== 32'd64000) begin tests_failed++; $display("FAIL clear_x_hold got %0d exp 64000", $signed(bus_a.x_o[31:0])); end
        tests_run++; if (bus_a.count_o !== 32'd3) begin tests_failed++; $display("FAIL clear_count_hold got %0d exp 3", bus_a.count_o); end
        @(posedge clk); #1;
        set_a(24'd1000, -24'sd1000, 24'd4194304, 24'd0);
        total = 0;
        for (int i = 0; i < 4; i++) begin tick_a(1, 9, fd, nd); if (i < 3) total += nd; end
        tests_run++; if (total !== 0) begin tests_failed++; $display("FAIL clear_early_done got %0d pulses exp 0", total); end
        tests_run++; if (fd !== 4) begin tests_failed++; $display("FAIL clear_done_cycle got %0d exp 4", fd); end
        @(negedge clk);
        tests_run++; if (bus_a.x_o !== {-32'sd64000, 32'sd64000}) begin tests_failed++; $display("FAIL clear_x got %0h exp ffff06000000fa00", bus_a.x_o); end
        tests_run++; if (bus_a.y_o !== 64'd0) begin tests_failed++; $display("FAIL clear_y got %0h exp 0", bus_a.y_o); end
        tests_run++; if (bus_a.count_o !== 32'd4) begin tests_failed++; $display("FAIL clear_count got %0d exp 4", bus_a.count_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int fd, nd;
        int total;
        set_a(24'd1000, -24'sd1000, 24'd4194304, 24'd0);
        for (int i = 0; i < 3; i++) tick_a(1, 9, fd, nd);
        bus_a.tick_i = 1'b1;
        @(posedge clk);
        #1 bus_a.tick_i = 1'b0;
        // now in the first MAC cycle of the final sample
        reset_n = 1'b0;
        total = 0;
        @(negedge clk);
        if (bus_a.done_o === 1'b1) total++;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus_a.done_o === 1'b1) total++;
        end
        tests_run++; if (total !== 0) begin tests_failed++; $display("FAIL rstmid_no_done got %0d pulses exp 0", total); end
        tests_run++; if (bus_a.x_o !== 64'd0) begin tests_failed++; $display("FAIL rstmid_x got %0h exp 0", bus_a.x_o); end
        tests_run++; if (bus_a.y_o !== 64'd0) begin tests_failed++; $display("FAIL rstmid_y got %0h exp 0", bus_a.y_o); end
        tests_run++; if (bus_a.count_o !== 32'd0) begin tests_failed++; $display("FAIL rstmid_count got %0d exp 0", bus_a.count_o); end
        tests_run++; if (bus_a.busy_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b exp 0", bus_a.busy_o); end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) tick_a(1, 9, fd, nd);
        tests_run++; if (fd !== 4) begin tests_failed++; $display("FAIL rstmid_done_cycle got %0d exp 4", fd); end
        @(negedge clk);
        tests_run++; if (bus_a.x_o[31:0] !== 32'd64000) begin tests_failed++; $display("FAIL rstmid_x0 got %0d exp 64000", $signed(bus_a.x_o[31:0])); end
        tests_run++; if (bus_a.count_o !== 32'd1) begin tests_failed++; $display("FAIL rstmid_count_after got %0d exp 1", bus_a.count_o); end
        @(posedge clk); #1;
    endtask

    // Ticks at the minimum non-dump spacing of NUM_CH+1 cycles.
    task automatic test_back_to_back();
        int fd, nd;
        set_a(24'd1000, -24'sd1000, 24'd4194304, 24'd0);
        for (int i = 0; i < 3; i++) tick_a(1, 2, fd, nd);
        tick_a(1, 9, fd, nd);
        tests_run++; if (fd !== 4) begin tests_failed++; $display("FAIL b2b_done_cycle got %0d exp 4", fd); end
        @(negedge clk);
        tests_run++; if (bus_a.missed_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_missed got %b exp 0", bus_a.missed_o); end
        tests_run++; if (bus_a.x_o[63:32] !== -32'sd64000) begin tests_failed++; $display("FAIL b2b_x1 got %0d exp -64000", $signed(bus_a.x_o[63:32])); end
        tests_run++; if (bus_a.count_o !== 32'd2) begin tests_failed++; $display("FAIL b2b_count got %0d exp 2", bus_a.count_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_decim1();
        int fd, nd;
        bus_b.data_i = 24'd3;
        bus_b.sin_i  = 24'd5;
        bus_b.cos_i  = -24'sd7;
        for (int i = 0; i < 3; i++) begin
            tick_b(3, fd, nd);
            tests_run++; if (fd !== 3) begin tests_failed++; $display("FAIL d1_done_cycle tick %0d got %0d exp 3", i, fd); end
            tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL d1_done_pulses tick %0d got %0d exp 1", i, nd); end
        end
        @(negedge clk);
        tests_run++; if (bus_b.x_o !== 32'd0) begin tests_failed++; $display("FAIL d1_x got %0h exp 0", bus_b.x_o); end
        tests_run++; if (bus_b.y_o !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL d1_y got %0h exp ffffffff", bus_b.y_o); end
        tests_run++; if (bus_b.count_o !== 32'd3) begin tests_failed++; $display("FAIL d1_count got %0d exp 3", bus_b.count_o); end
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        bus_a.clear_i = 1'b0; bus_a.tick_i = 1'b0; bus_a.data_i = '0; bus_a.sin_i = '0; bus_a.cos_i = '0;
        bus_b.clear_i = 1'b0; bus_b.tick_i = 1'b0; bus_b.data_i = '0; bus_b.sin_i = '0; bus_b.cos_i = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        test_reset();
        test_basic();
        test_extreme();
        test_missed();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        test_decim1();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/multichannel_lockin.md
Name: multichannel_lockin

Overview:
- Parametrised, time-multiplexed lock-in demodulator for NUM_CH ADC/filter channels against one shared reference pair (sin, cos).
- Uses one multiplier pair, iterating over channels, and integrates and dumps over DECIM reference samples (boxcar low-pass plus decimation).
- Produces per-channel X/Y words sized for the 32-bit AXI GPIO readout, plus an update counter and a sticky missed-tick flag.
- Sits after the input filters / Hilbert transformer; replaces the fixed one- and two-channel lock-in/demodulator instances.

Parameters:
- NUM_CH, 4, number of input channels (>=1).
- DATA_W, 24, signed width of each data, sin and cos sample.
- DECIM, 16, samples integrated per output; power of two, >=1.
- OUT_W, 32, signed width of each X/Y output; must satisfy OUT_W <= ACC_W.
- ACC_W (derived, not overridable), 2*DATA_W+$clog2(DECIM), accumulator width.

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous clear of integration state.
- tick_i  in  1  new sample strobe, one cycle.
- data_i  in  NUM_CH*DATA_W  signed samples; channel k occupies bits [k*DATA_W +: DATA_W].
- sin_i  in  DATA_W  signed in-phase reference.
- cos_i  in  DATA_W  signed quadrature reference.
- x_o  out  NUM_CH*OUT_W  in-phase results, same packing.
- y_o  out  NUM_CH*OUT_W  quadrature results.
- done_o  out  1  one-cycle strobe when x_o/y_o update.
- busy_o  out  1  high while not IDLE.
- count_o  out  32  unsigned count of done_o pulses; wraps 2^32-1 -> 0.
- missed_o  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; accumulators, channel index and sample counter = 0.
  - x_o, y_o, count_o = 0; done_o, busy_o, missed_o = 0.
- FSM states: IDLE, MAC, DUMP.
- IDLE:
  - On tick_i, register data_i, sin_i and cos_i into snapshot registers and go to MAC.
  - Tick in cycle 0 means MAC occupies cycles 1..NUM_CH.
- MAC, one channel per cycle, k = 0..NUM_CH-1:
  - acc_x[k] += d_k*sin and acc_y[k] += d_k*cos.
  - Products are full 2*DATA_W signed; accumulators are ACC_W signed, so no overflow is possible for any input values.
- After channel NUM_CH-1:
  - If sample counter == DECIM-1: go to DUMP, sample counter = 0.
  - Otherwise: sample counter += 1, return to IDLE.
- DUMP (cycle NUM_CH+1 after the final tick):
  - x_o[k] = acc_x[k][ACC_W-1 -: OUT_W], arithmetic truncation (floor); y_o likewise.
  - Clear all accumulators and increment count_o.
  - Return to IDLE.
  - done_o = 1 during cycle NUM_CH+2 only, coincident with new x_o/y_o; outputs hold until the next DUMP.
- DECIM=1: every tick produces a DUMP.
- Throughput: ticks spaced >= NUM_CH+1 cycles (non-dump) or NUM_CH+2 cycles (dump) are all accepted.
- tick_i while busy_o=1:
  - Tick is ignored (no snapshot, no counter change) and missed_o is set.
  - Exception: a tick in the same cycle the FSM returns to IDLE from DUMP is also ignored.
- clear_i = 1 (any state):
  - Next cycle: state = IDLE, accumulators = 0, sample counter = 0, missed_o = 0.
  - Held unchanged: x_o, y_o, count_o.
  - done_o is not asserted for an aborted integration.
- clear_i and tick_i in the same cycle: clear wins; tick dropped and not counted as missed.
- reset_ni low mid-MAC or mid-DUMP: immediate return to reset values; no done_o.
- busy_o = (state != IDLE), registered.

Test Plan:
- NUM_CH=2, DECIM=4, OUT_W=32 (ACC_W=50, output = acc[49:18]); 4 ticks, spaced 10 cycles, with ch0=1000, ch1=-1000, sin=4194304, cos=0 -> after the 4th tick, done_o high exactly at cycle 4, x_o ch0=64000, ch1=-64000, y_o=0, count_o=1, no done_o after ticks 1-3.
- Same configuration, data=-8388608, sin=cos=-8388608 for 4 ticks -> x_o=y_o=1073741824 for both channels, no wrap.
- Tick at cycle 0 and cycle 1 -> second tick ignored, missed_o=1 and stays 1; only 3 further ticks are needed for the next done_o; clear_i pulse -> missed_o=0.
- clear_i asserted after 2 of 4 ticks -> no done_o; the next 4 ticks give x_o=64000, i.e. no residue from aborted samples; x_o and count_o unchanged in between.
- reset_ni pulsed low during MAC of the 4th tick -> x_o=y_o=count_o=0, done_o never asserts; a full 4-tick run afterwards gives the expected values.
- DECIM=1, NUM_CH=1, data=3, sin=5, cos=-7 (ACC_W=48, output = acc[47:16]) -> x_o=0, y_o=-1 (floor of -21/65536), done_o at cycle 3 after every tick, count_o increments per tick.
